// File: rtl/sc_levelsequencer_p2_if.sv
// Player-2 sequencer bus: control inputs from the game logic and the
// {Current, Progress} pair plus status pulses going to the level manager.
interface sc_levelsequencer_p2_if;
  logic       SC_LEVELSEQUENCER_P2_Start_InLow;
  logic       SC_LEVELSEQUENCER_P2_Tick_In;
  logic       SC_LEVELSEQUENCER_P2_Pause_In;
  logic       SC_LEVELSEQUENCER_P2_Crash_In;
  logic [2:0] SC_LEVELSEQUENCER_P2_Current_OutBus;
  logic [4:0] SC_LEVELSEQUENCER_P2_Progress_OutBus;
  logic       SC_LEVELSEQUENCER_P2_Active_Out;
  logic       SC_LEVELSEQUENCER_P2_StageDone_Out;
  logic       SC_LEVELSEQUENCER_P2_Win_Out;

  // Game-logic side: drives the requests, observes the stage outputs.
  modport master (
    output SC_LEVELSEQUENCER_P2_Start_InLow,
    output SC_LEVELSEQUENCER_P2_Tick_In,
    output SC_LEVELSEQUENCER_P2_Pause_In,
    output SC_LEVELSEQUENCER_P2_Crash_In,
    input  SC_LEVELSEQUENCER_P2_Current_OutBus,
    input  SC_LEVELSEQUENCER_P2_Progress_OutBus,
    input  SC_LEVELSEQUENCER_P2_Active_Out,
    input  SC_LEVELSEQUENCER_P2_StageDone_Out,
    input  SC_LEVELSEQUENCER_P2_Win_Out
  );

  // Sequencer side.
  modport slave (
    input  SC_LEVELSEQUENCER_P2_Start_InLow,
    input  SC_LEVELSEQUENCER_P2_Tick_In,
    input  SC_LEVELSEQUENCER_P2_Pause_In,
    input  SC_LEVELSEQUENCER_P2_Crash_In,
    output SC_LEVELSEQUENCER_P2_Current_OutBus,
    output SC_LEVELSEQUENCER_P2_Progress_OutBus,
    output SC_LEVELSEQUENCER_P2_Active_Out,
    output SC_LEVELSEQUENCER_P2_StageDone_Out,
    output SC_LEVELSEQUENCER_P2_Win_Out
  );
endinterface

// File: rtl/sc_levelsequencer_p2.sv
// Player-2 track sequencer: walks transition/level stages 1..6 driven by a
// prescaled scroll tick, with start, pause, crash-restart and end-of-game.
module sc_levelsequencer_p2 #(
  parameter int unsigned TICKS_PER_STEP = 4,
  parameter int unsigned LEN_TRANS      = 8,
  parameter int unsigned LEN_LV1        = 10,
  parameter int unsigned LEN_LV2        = 15,
  parameter int unsigned LEN_LV3        = 20
) (
  input  logic                  SC_LEVELSEQUENCER_P2_CLOCK_50,
  input  logic                  SC_LEVELSEQUENCER_P2_RESET_InLow,
  sc_levelsequencer_p2_if.slave bus
);

  localparam logic [7:0] PRE_LAST  = 8'(TICKS_PER_STEP - 1);
  localparam logic [4:0] L_TRANS   = 5'(LEN_TRANS);
  localparam logic [4:0] L_LV1     = 5'(LEN_LV1);
  localparam logic [4:0] L_LV2     = 5'(LEN_LV2);
  localparam logic [4:0] L_LV3     = 5'(LEN_LV3);
  localparam logic [2:0] LAST_STAGE = 3'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  logic [7:0] pre;
  logic [2:0] current;
  logic [4:0] progress;
  logic       active;
  logic       stage_done;
  logic       win;

  logic clk;
  logic rst_n;
  logic start_n;
  logic tick;
  logic pause;
  logic crash;

  assign clk     = SC_LEVELSEQUENCER_P2_CLOCK_50;
  assign rst_n   = SC_LEVELSEQUENCER_P2_RESET_InLow;
  assign start_n = bus.SC_LEVELSEQUENCER_P2_Start_InLow;
  assign tick    = bus.SC_LEVELSEQUENCER_P2_Tick_In;
  assign pause   = bus.SC_LEVELSEQUENCER_P2_Pause_In;
  assign crash   = bus.SC_LEVELSEQUENCER_P2_Crash_In;

  // Row count of each stage; odd stages are the shared transition length.
  function automatic logic [4:0] stage_len(input logic [2:0] stage);
    logic [4:0] len;
    case (stage)
      3'd2:    len = L_LV1;
      3'd4:    len = L_LV2;
      3'd6:    len = L_LV3;
      default: len = L_TRANS;
    endcase
    return len;
  endfunction

  // Sequencer FSM; all outputs are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pre        <= 8'd0;
      current    <= 3'd0;
      progress   <= 5'd0;
      active     <= 1'b0;
      stage_done <= 1'b0;
      win        <= 1'b0;
    end else begin
      // Status pulses last exactly one cycle.
      stage_done <= 1'b0;
      win        <= 1'b0;
      case (state)
        IDLE, DONE: begin
          // Start beats any coincident crash; tick/pause/crash are ignored.
          if (!start_n) begin
            state    <= RUN;
            current  <= 3'd1;
            progress <= 5'd1;
            pre      <= 8'd0;
            active   <= 1'b1;
          end
        end
        RUN: begin
          if (crash) begin
            // Restart the current stage; applies even while paused.
            progress <= 5'd1;
            pre      <= 8'd0;
          end else if (pause) begin
            // Freeze: everything holds, ticks are dropped.
          end else if (tick) begin
            if (pre < PRE_LAST) begin
              pre <= pre + 8'd1;
            end else begin
              pre <= 8'd0;
              if (progress < stage_len(current)) begin
                progress <= progress + 5'd1;
              end else if (current < LAST_STAGE) begin
                current    <= current + 3'd1;
                progress   <= 5'd1;
                stage_done <= 1'b1;
              end else begin
                // Final row of stage 6 consumed: game won, blank the row.
                state    <= DONE;
                current  <= 3'd0;
                progress <= 5'd0;
                active   <= 1'b0;
                win      <= 1'b1;
              end
            end
          end
        end
        default: begin
          state    <= IDLE;
          current  <= 3'd0;
          progress <= 5'd0;
          pre      <= 8'd0;
          active   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.SC_LEVELSEQUENCER_P2_Current_OutBus  = current;
  assign bus.SC_LEVELSEQUENCER_P2_Progress_OutBus = progress;
  assign bus.SC_LEVELSEQUENCER_P2_Active_Out      = active;
  assign bus.SC_LEVELSEQUENCER_P2_StageDone_Out   = stage_done;
  assign bus.SC_LEVELSEQUENCER_P2_Win_Out         = win;

endmodule

// File: tb/tb_sc_levelsequencer_p2.sv
// Scoreboard bench: two sequencers (TICKS_PER_STEP 4 and 1) share a clock;
// stimulus pushes hand-computed expectations, a monitor pops and compares.
module tb_sc_levelsequencer_p2;

  logic clk;
  logic rst_n;

  sc_levelsequencer_p2_if ia ();
  sc_levelsequencer_p2_if ib ();

  sc_levelsequencer_p2 #(.TICKS_PER_STEP(4)) dut_a (
    .SC_LEVELSEQUENCER_P2_CLOCK_50   (clk),
    .SC_LEVELSEQUENCER_P2_RESET_InLow(rst_n),
    .bus                             (ia.slave)
  );

  sc_levelsequencer_p2 #(.TICKS_PER_STEP(1)) dut_b (
    .SC_LEVELSEQUENCER_P2_CLOCK_50   (clk),
    .SC_LEVELSEQUENCER_P2_RESET_InLow(rst_n),
    .bus                             (ib.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         dut;
    logic [2:0] cur;
    logic [4:0] prog;
    logic       act;
    logic       sd;
    logic       win;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic expect_out(input int d, input logic [2:0] c, input logic [4:0] p,
                            input logic a, input logic sd, input logic w, input string n);
    exp_t e;
    e.dut = d; e.cur = c; e.prog = p; e.act = a; e.sd = sd; e.win = w; e.name = n;
    exp_q.push_back(e);
  endtask

  task automatic chk_int(input string n, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", n, got, want);
    end
  endtask

  // Monitor: compare every queued expectation against the named DUT.
  exp_t       m_e;
  logic [2:0] m_cur;
  logic [4:0] m_prog;
  logic       m_act, m_sd, m_win;
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      m_e = exp_q.pop_front();
      if (m_e.dut == 0) begin
        m_cur  = ia.SC_LEVELSEQUENCER_P2_Current_OutBus;
        m_prog = ia.SC_LEVELSEQUENCER_P2_Progress_OutBus;
        m_act  = ia.SC_LEVELSEQUENCER_P2_Active_Out;
        m_sd   = ia.SC_LEVELSEQUENCER_P2_StageDone_Out;
        m_win  = ia.SC_LEVELSEQUENCER_P2_Win_Out;
      end else begin
        m_cur  = ib.SC_LEVELSEQUENCER_P2_Current_OutBus;
        m_prog = ib.SC_LEVELSEQUENCER_P2_Progress_OutBus;
        m_act  = ib.SC_LEVELSEQUENCER_P2_Active_Out;
        m_sd   = ib.SC_LEVELSEQUENCER_P2_StageDone_Out;
        m_win  = ib.SC_LEVELSEQUENCER_P2_Win_Out;
      end
      n_checks++;
      if (m_cur !== m_e.cur || m_prog !== m_e.prog || m_act !== m_e.act ||
          m_sd !== m_e.sd || m_win !== m_e.win) begin
        n_fail++;
        $display("FAIL %s: got cur=%0d prog=%0d act=%b sd=%b win=%b expected cur=%0d prog=%0d act=%b sd=%b win=%b",
                 m_e.name, m_cur, m_prog, m_act, m_sd, m_win,
                 m_e.cur, m_e.prog, m_e.act, m_e.sd, m_e.win);
      end
    end
  end

  task automatic cyc_a(input logic s_n, input logic t, input logic p, input logic c);
    ia.SC_LEVELSEQUENCER_P2_Start_InLow = s_n;
    ia.SC_LEVELSEQUENCER_P2_Tick_In     = t;
    ia.SC_LEVELSEQUENCER_P2_Pause_In    = p;
    ia.SC_LEVELSEQUENCER_P2_Crash_In    = c;
    @(posedge clk);
    #1;
    ia.SC_LEVELSEQUENCER_P2_Start_InLow = 1'b1;
    ia.SC_LEVELSEQUENCER_P2_Tick_In     = 1'b0;
    ia.SC_LEVELSEQUENCER_P2_Pause_In    = 1'b0;
    ia.SC_LEVELSEQUENCER_P2_Crash_In    = 1'b0;
  endtask

  task automatic cyc_b(input logic s_n, input logic t, input logic p, input logic c);
    ib.SC_LEVELSEQUENCER_P2_Start_InLow = s_n;
    ib.SC_LEVELSEQUENCER_P2_Tick_In     = t;
    ib.SC_LEVELSEQUENCER_P2_Pause_In    = p;
    ib.SC_LEVELSEQUENCER_P2_Crash_In    = c;
    @(posedge clk);
    #1;
    ib.SC_LEVELSEQUENCER_P2_Start_InLow = 1'b1;
    ib.SC_LEVELSEQUENCER_P2_Tick_In     = 1'b0;
    ib.SC_LEVELSEQUENCER_P2_Pause_In    = 1'b0;
    ib.SC_LEVELSEQUENCER_P2_Crash_In    = 1'b0;
  endtask

  task automatic ticks_a(input int n);
    for (int i = 0; i < n; i++) cyc_a(1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int sd_cnt;
  int win_cnt;

  initial begin
    rst_n = 1'b0;
    ia.SC_LEVELSEQUENCER_P2_Start_InLow = 1'b1;
    ia.SC_LEVELSEQUENCER_P2_Tick_In     = 1'b0;
    ia.SC_LEVELSEQUENCER_P2_Pause_In    = 1'b0;
    ia.SC_LEVELSEQUENCER_P2_Crash_In    = 1'b0;
    ib.SC_LEVELSEQUENCER_P2_Start_InLow = 1'b1;
    ib.SC_LEVELSEQUENCER_P2_Tick_In     = 1'b0;
    ib.SC_LEVELSEQUENCER_P2_Pause_In    = 1'b0;
    ib.SC_LEVELSEQUENCER_P2_Crash_In    = 1'b0;
    @(posedge clk);
    #1;
    expect_out(0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, "reset_a");
    expect_out(1, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, "reset_b");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // ---- DUT A, TICKS_PER_STEP = 4 ----
    cyc_a(1'b1, 1'b1, 1'b0, 1'b1);
    expect_out(0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, "idle_ignores_tick_crash");
    cyc_a(1'b0, 1'b0, 1'b0, 1'b1);
    expect_out(0, 3'd1, 5'd1, 1'b1, 1'b0, 1'b0, "start_with_crash");
    ticks_a(3);
    expect_out(0, 3'd1, 5'd1, 1'b1, 1'b0, 1'b0, "three_ticks_hold");
    ticks_a(1);
    expect_out(0, 3'd1, 5'd2, 1'b1, 1'b0, 1'b0, "fourth_tick_steps");
    ticks_a(24);
    expect_out(0, 3'd1, 5'd8, 1'b1, 1'b0, 1'b0, "stage1_end");
    ticks_a(4);
    expect_out(0, 3'd2, 5'd1, 1'b1, 1'b1, 1'b0, "stage_advance");
    cyc_a(1'b0, 1'b0, 1'b0, 1'b0);
    expect_out(0, 3'd2, 5'd1, 1'b1, 1'b0, 1'b0, "sd_one_cycle_start_ignored");
    ticks_a(104);
    expect_out(0, 3'd4, 5'd9, 1'b1, 1'b0, 1'b0, "reach_4_9");
    ticks_a(2);
    cyc_a(1'b1, 1'b1, 1'b0, 1'b1);
    expect_out(0, 3'd4, 5'd1, 1'b1, 1'b0, 1'b0, "crash_with_tick");
    ticks_a(3);
    expect_out(0, 3'd4, 5'd1, 1'b1, 1'b0, 1'b0, "crash_cleared_pre");
    ticks_a(1);
    expect_out(0, 3'd4, 5'd2, 1'b1, 1'b0, 1'b0, "post_crash_step");
    ticks_a(1);
    for (int i = 0; i < 10; i++) cyc_a(1'b1, 1'b1, 1'b1, 1'b0);
    expect_out(0, 3'd4, 5'd2, 1'b1, 1'b0, 1'b0, "pause_freeze");
    ticks_a(2);
    expect_out(0, 3'd4, 5'd2, 1'b1, 1'b0, 1'b0, "pause_pre_held");
    ticks_a(1);
    expect_out(0, 3'd4, 5'd3, 1'b1, 1'b0, 1'b0, "resume_step");
    cyc_a(1'b1, 1'b1, 1'b1, 1'b1);
    expect_out(0, 3'd4, 5'd1, 1'b1, 1'b0, 1'b0, "crash_during_pause");
    ticks_a(5);
    #2;
    rst_n = 1'b0;
    #1;
    expect_out(0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, "reset_midrun");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc_a(1'b1, 1'b1, 1'b0, 1'b0);
    expect_out(0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, "after_reset_needs_start");

    // ---- DUT B, TICKS_PER_STEP = 1, full game ----
    cyc_b(1'b0, 1'b0, 1'b0, 1'b0);
    expect_out(1, 3'd1, 5'd1, 1'b1, 1'b0, 1'b0, "b_start");
    sd_cnt  = 0;
    win_cnt = 0;
    for (int i = 1; i <= 69; i++) begin
      cyc_b(1'b1, 1'b1, 1'b0, 1'b0);
      if (ib.SC_LEVELSEQUENCER_P2_StageDone_Out === 1'b1) sd_cnt++;
      if (ib.SC_LEVELSEQUENCER_P2_Win_Out === 1'b1) win_cnt++;
      if (i == 7)  expect_out(1, 3'd1, 5'd8,  1'b1, 1'b0, 1'b0, "b_stage1_end");
      if (i == 8)  expect_out(1, 3'd2, 5'd1,  1'b1, 1'b1, 1'b0, "b_stage2_begin");
      if (i == 68) expect_out(1, 3'd6, 5'd20, 1'b1, 1'b0, 1'b0, "b_last_row");
      if (i == 69) expect_out(1, 3'd0, 5'd0,  1'b0, 1'b0, 1'b1, "b_win");
    end
    cyc_b(1'b1, 1'b0, 1'b0, 1'b0);
    if (ib.SC_LEVELSEQUENCER_P2_Win_Out === 1'b1) win_cnt++;
    expect_out(1, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, "b_win_one_cycle");
    chk_int("b_stagedone_count", sd_cnt, 5);
    chk_int("b_win_count", win_cnt, 1);
    cyc_b(1'b1, 1'b1, 1'b1, 1'b1);
    expect_out(1, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, "b_done_ignores");
    cyc_b(1'b0, 1'b0, 1'b0, 1'b0);
    expect_out(1, 3'd1, 5'd1, 1'b1, 1'b0, 1'b0, "b_restart");

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
